// File: rtl/bram2uart_dump_if.sv
// bram2uart_dump_if
//   Bundles the two buses the screen dumper talks on:
//     - screen BRAM read port : bram_addr (to BRAM), bram_rdata (from BRAM,
//       registered read, valid one cycle after the address)
//     - UART byte handshake   : tx_data / tx_valid (to transmitter),
//       tx_ready (from transmitter); a byte moves when valid and ready are
//       both high on a rising clock edge.
//   master : the dumper side (drives address and byte stream)
//   slave  : the BRAM / transmitter side
interface bram2uart_dump_if #(
    parameter int SCREEN_ADDRESS_WIDTH = 13
);
    logic [SCREEN_ADDRESS_WIDTH-1:0] bram_addr;
    logic [6:0]                      bram_rdata;
    logic [7:0]                      tx_data;
    logic                            tx_valid;
    logic                            tx_ready;

    modport master (
        output bram_addr,
        output tx_data,
        output tx_valid,
        input  bram_rdata,
        input  tx_ready
    );

    modport slave (
        input  bram_addr,
        input  tx_data,
        input  tx_valid,
        output bram_rdata,
        output tx_ready
    );
endinterface

// File: rtl/bram2uart_dump.sv
// bram2uart_dump
//   Walks the character screen BRAM row by row, top-left first, and streams
//   every character out as one UART byte. Each row is followed by CR, LF.
//   NUL cells are sent as spaces so the terminal keeps its column alignment.
//   A single-cycle start request launches one full-screen dump.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : dump request, only honoured while idle
//   busy   : dump in progress (cycle after accepted start .. final LF)
//   done   : one-cycle pulse after the final LF has been transferred
//   bus    : master side of bram2uart_dump_if (BRAM read port + UART bytes)
module bram2uart_dump #(
    parameter int SCREEN_ADDRESS_WIDTH  = 13,
    parameter int HORIZONTAL_SLOT_COUNT = 80,
    parameter int VERTICAL_SLOT_COUNT   = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    bram2uart_dump_if.master     bus
);

    localparam int COL_W = (HORIZONTAL_SLOT_COUNT > 1) ? $clog2(HORIZONTAL_SLOT_COUNT) : 1;
    localparam int ROW_W = (VERTICAL_SLOT_COUNT > 1) ? $clog2(VERTICAL_SLOT_COUNT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(HORIZONTAL_SLOT_COUNT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VERTICAL_SLOT_COUNT - 1);

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SEND_CHAR,
        S_SEND_CR,
        S_SEND_LF
    } state_t;

    state_t                          r_state;
    logic [SCREEN_ADDRESS_WIDTH-1:0] r_bram_addr;
    logic [COL_W-1:0]                r_col;
    logic [ROW_W-1:0]                r_row;
    logic [7:0]                      r_tx_data;
    logic                            r_tx_valid;
    logic                            r_busy;
    logic                            r_done;
    logic                            w_xfer;

    // Empty cells are stored as 0; show them as blanks on the terminal.
    function automatic logic [7:0] map_char(input logic [6:0] c);
        map_char = (c == 7'd0) ? CHAR_SPACE : {1'b0, c};
    endfunction

    assign w_xfer = r_tx_valid & bus.tx_ready;

    assign bus.bram_addr = r_bram_addr;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bram_addr <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // A start coinciding with the done pulse belongs to the
                    // dump that just finished and is dropped.
                    if (start && !r_done) begin
                        r_state     <= S_READ;
                        r_bram_addr <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_busy      <= 1'b1;
                    end
                end

                // Address is presented here; the registered BRAM answers
                // in the following cycle.
                S_READ: begin
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    r_tx_data  <= map_char(bus.bram_rdata);
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND_CHAR;
                end

                S_SEND_CHAR: begin
                    if (w_xfer) begin
                        if (r_col == COL_LAST) begin
                            // Valid stays high: CR follows without a gap.
                            r_tx_data <= CHAR_CR;
                            r_state   <= S_SEND_CR;
                        end else begin
                            r_col       <= r_col + 1'b1;
                            r_bram_addr <= r_bram_addr + 1'b1;
                            r_tx_valid  <= 1'b0;
                            r_state     <= S_READ;
                        end
                    end
                end

                S_SEND_CR: begin
                    if (w_xfer) begin
                        r_tx_data <= CHAR_LF;
                        r_state   <= S_SEND_LF;
                    end
                end

                S_SEND_LF: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        if (r_row == ROW_LAST) begin
                            // Address stays on the last cell; never wraps past it.
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_row       <= r_row + 1'b1;
                            r_col       <= '0;
                            r_bram_addr <= r_bram_addr + 1'b1;
                            r_state     <= S_READ;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram2uart_dump.sv
// tb_bram2uart_dump
//   Small instance (H=4, V=2) driven from a vector table of screen cells and
//   expected bytes, plus a default-size instance for the full 80x60 dump.
module tb_bram2uart_dump;

    logic clk;
    logic rst;
    logic start_s, busy_s, done_s;
    logic start_b, busy_b, done_b;

    bram2uart_dump_if #(.SCREEN_ADDRESS_WIDTH(13)) bus_s ();
    bram2uart_dump_if #(.SCREEN_ADDRESS_WIDTH(13)) bus_b ();

    bram2uart_dump #(
        .SCREEN_ADDRESS_WIDTH (13),
        .HORIZONTAL_SLOT_COUNT(4),
        .VERTICAL_SLOT_COUNT  (2)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .start(start_s),
        .busy (busy_s),
        .done (done_s),
        .bus  (bus_s)
    );

    bram2uart_dump u_dut_big (
        .clk  (clk),
        .rst  (rst),
        .start(start_b),
        .busy (busy_b),
        .done (done_b),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_char;
        logic [2:0] addr;
        logic [6:0] mem_in;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t       tab[12];
    logic [6:0] mem[8];

    int errors = 0;
    int checks = 0;

    // ---------------- small-instance monitor state ----------------
    logic [7:0] cap_q[$];
    int         addr_q[$];
    int         done_cnt, done_gap, busy_drop, cap_err, stab_err, max_addr;
    int         ncyc, last_xfer_n;
    logic       prev_valid, prev_stall;
    logic [7:0] prev_data;

    // ---------------- big-instance monitor state ----------------
    int big_bytes, big_err, big_max_addr, big_last_addr, big_done;

    // tx_ready drive
    logic rand_mode, ready_fixed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_mon();
        cap_q.delete();
        addr_q.delete();
        done_cnt   = 0;
        done_gap   = -1;
        busy_drop  = 0;
        cap_err    = 0;
        stab_err   = 0;
        max_addr   = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
    endtask

    // Registered-read model of the small screen BRAM.
    always @(posedge clk) begin
        bus_s.bram_rdata <= (bus_s.bram_addr < 13'd8) ? mem[bus_s.bram_addr[2:0]] : 7'd0;
        bus_b.bram_rdata <= 7'd0;
    end

    initial begin
        bus_b.tx_ready = 1'b1;
        bus_s.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_s.tx_ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_fixed;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_c;
        if (bus_s.tx_valid && bus_s.tx_ready) begin
            cap_q.push_back(bus_s.tx_data);
            last_xfer_n = ncyc;
        end
        if (bus_s.tx_valid && !prev_valid) begin
            addr_q.push_back(int'(bus_s.bram_addr));
            exp_c = (bus_s.bram_addr < 13'd8) ?
                    ((mem[bus_s.bram_addr[2:0]] == 7'd0) ? 8'h20 : {1'b0, mem[bus_s.bram_addr[2:0]]}) : 8'hFF;
            if (bus_s.tx_data !== exp_c) cap_err++;
        end
        if (int'(bus_s.bram_addr) > max_addr) max_addr = int'(bus_s.bram_addr);
        if (prev_stall && (!bus_s.tx_valid || bus_s.tx_data !== prev_data)) stab_err++;
        if (done_s) begin
            done_cnt++;
            done_gap = ncyc - last_xfer_n;
        end
        if (!busy_s && cap_q.size() > 0 && cap_q.size() < 12) busy_drop++;
        prev_valid = bus_s.tx_valid;
        prev_stall = bus_s.tx_valid && !bus_s.tx_ready;
        prev_data  = bus_s.tx_data;
        ncyc++;

        if (bus_b.tx_valid && bus_b.tx_ready) begin
            exp_c = ((big_bytes % 82) < 80) ? 8'h20 : (((big_bytes % 82) == 80) ? 8'h0D : 8'h0A);
            if (bus_b.tx_data !== exp_c) big_err++;
            big_bytes++;
        end
        big_last_addr = int'(bus_b.bram_addr);
        if (big_last_addr > big_max_addr) big_max_addr = big_last_addr;
        if (done_b) big_done++;
    end

    task automatic pulse_start_s();
        @(posedge clk);
        #1 start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
    endtask

    task automatic wait_done_s(input string name, input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_dump(input string name);
        chk({name, "_count"}, 32'(cap_q.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_byte%0d", name, i), (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF, 32'(tab[i].exp_tx));
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({name, "_done_gap"}, 32'(done_gap), 32'd1);
        chk({name, "_busy_held"}, 32'(busy_drop), 32'd0);
        chk({name, "_busy_after"}, 32'(busy_s), 32'd0);
        chk({name, "_stable"}, 32'(stab_err), 32'd0);
        chk({name, "_capture"}, 32'(cap_err), 32'd0);
        chk({name, "_max_addr"}, 32'(max_addr), 32'd7);
        chk({name, "_addr_count"}, 32'(addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_addr%0d", name, i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF, 32'(i));
    endtask

    initial begin
        int n;

        tab[0]  = '{1'b1, 3'd0, 7'h41, 8'h41};
        tab[1]  = '{1'b1, 3'd1, 7'h42, 8'h42};
        tab[2]  = '{1'b1, 3'd2, 7'h00, 8'h20};
        tab[3]  = '{1'b1, 3'd3, 7'h44, 8'h44};
        tab[4]  = '{1'b0, 3'd0, 7'h00, 8'h0D};
        tab[5]  = '{1'b0, 3'd0, 7'h00, 8'h0A};
        tab[6]  = '{1'b1, 3'd4, 7'h77, 8'h77};
        tab[7]  = '{1'b1, 3'd5, 7'h78, 8'h78};
        tab[8]  = '{1'b1, 3'd6, 7'h79, 8'h79};
        tab[9]  = '{1'b1, 3'd7, 7'h7A, 8'h7A};
        tab[10] = '{1'b0, 3'd0, 7'h00, 8'h0D};
        tab[11] = '{1'b0, 3'd0, 7'h00, 8'h0A};
        for (int i = 0; i < 8; i++) mem[i] = 7'd0;
        for (int i = 0; i < 12; i++)
            if (tab[i].is_char) mem[tab[i].addr] = tab[i].mem_in;

        ncyc = 0;
        last_xfer_n = 0;
        big_bytes = 0; big_err = 0; big_max_addr = 0; big_last_addr = 0; big_done = 0;
        rand_mode = 1'b0;
        ready_fixed = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        reset_mon();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_tx_valid", 32'(bus_s.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus_s.tx_data), 32'd0);
        chk("rst_bram_addr", 32'(bus_s.bram_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: ready tied high
        reset_mon();
        pulse_start_s();
        #1 chk("t1_busy_after_start", 32'(busy_s), 32'd1);
        wait_done_s("t1", 200);
        check_dump("t1");

        // Test 2: ready toggling ~30% high
        rand_mode = 1'b1;
        reset_mon();
        pulse_start_s();
        wait_done_s("t2", 3000);
        check_dump("t2");
        rand_mode = 1'b0;

        // Test 4: extra start after the 5th transfer is ignored
        reset_mon();
        pulse_start_s();
        n = 0;
        while (cap_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_5", 32'(cap_q.size() >= 5), 32'd1);
        pulse_start_s();
        wait_done_s("t4", 200);
        repeat (20) @(negedge clk);
        check_dump("t4");

        // Test 5: asynchronous reset while stalled in SEND_CHAR
        ready_fixed = 1'b0;
        reset_mon();
        pulse_start_s();
        n = 0;
        while (!bus_s.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_stalled_valid", 32'(bus_s.tx_valid), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_tx_valid", 32'(bus_s.tx_valid), 32'd0);
        chk("t5_async_busy", 32'(busy_s), 32'd0);
        chk("t5_async_done", 32'(done_s), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_fixed = 1'b1;
        reset_mon();
        pulse_start_s();
        wait_done_s("t5", 200);
        check_dump("t5");

        // Test 6: default geometry, all-zero screen
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        n = 0;
        while (big_done == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk("t6_done_pulses", 32'(big_done), 32'd1);
        chk("t6_bytes", 32'(big_bytes), 32'd4920);
        chk("t6_byte_errs", 32'(big_err), 32'd0);
        chk("t6_last_addr", 32'(big_last_addr), 32'd4799);
        chk("t6_max_addr", 32'(big_max_addr), 32'd4799);
        chk("t6_busy_after", 32'(busy_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
